trace_capture_buffer: RTL and testbench

Parametrised on-chip logic-analyzer buffer for board bring-up, replacing hand-wired single-mode debug capture in FPGA top levels. It continuously records a user-selected debug word into a circular RAM while armed. On a trigger, it records a programmable number of post-trigger samples, then streams the window oldest-first as a byte stream. That stream feeds the UART transmitter or the JTAG path through a valid/ready handshake, and the buffer re-arms on command.

---
 rtl/trace_capture_buffer.sv | 192 +++++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// Logic-analyzer trace buffer. It records debug words into a circular RAM and, after a
// trigger plus a programmable post-trigger window, streams the window oldest-first as bytes.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_CAPTURE | armed, recording enabled samples, waiting for trigger
// S_POST    | triggered, recording the remaining post-trigger samples
// S_DUMP    | streaming header + entries on the byte handshake
// S_DONE    | stream finished, waiting for arm
module trace_capture_buffer #(
  parameter int CAPTURE_WIDTH_BITS = 32,
  parameter int CAPTURE_SIZE       = 128,
  parameter int POST_TRIGGER       = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CAPTURE_WIDTH_BITS-1:0] capture_data,
  input  logic                          capture_enable,
  input  logic                          trigger,
  input  logic                          arm,
  output logic [7:0]                    dump_byte,
  output logic                          dump_byte_valid,
  input  logic                          dump_byte_ready,
  output logic                          armed,
  output logic                          triggered,
  output logic                          done
);

  localparam int B   = (CAPTURE_WIDTH_BITS + 7) / 8;
  localparam int SW  = B * 8;
  localparam int AW  = $clog2(CAPTURE_SIZE);
  localparam int FW  = $clog2(CAPTURE_SIZE + 1);
  localparam int PW  = $clog2(POST_TRIGGER + 1);
  localparam int BCW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {S_CAPTURE, S_POST, S_DUMP, S_DONE} state_t;
  typedef enum logic [2:0] {D_INIT, D_HDR0, D_HDR1, D_LOAD, D_BYTES} dphase_t;

  state_t  state;
  dphase_t dphase;

  logic [CAPTURE_WIDTH_BITS-1:0] mem [CAPTURE_SIZE];
  logic [CAPTURE_WIDTH_BITS-1:0] rd_q;

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [FW-1:0]  fill;
  logic [FW-1:0]  entries_left;
  logic [PW-1:0]  post_left;
  logic [BCW-1:0] byte_left;
  logic [SW-1:0]  shift;

  logic           wr_en;
  logic           fill_full;
  logic [AW-1:0]  oldest;
  logic [15:0]    entry_count;
  logic           xfer;
  logic [SW-1:0]  shift_next;
  logic [SW-1:0]  rd_ext;
  logic           trig_last;

  always_comb begin
    wr_en       = capture_enable && (state == S_CAPTURE || state == S_POST);
    fill_full   = (fill == FW'(CAPTURE_SIZE));
    oldest      = fill_full ? wr_ptr : '0;
    entry_count = 16'(fill);
    xfer        = dump_byte_valid && dump_byte_ready;
    shift_next  = shift >> 8;
    rd_ext      = SW'(rd_q);
    trig_last   = capture_enable && (POST_TRIGGER == 1);
  end

  // Single write port, single synchronous read port; dump reads only happen
  // in S_DUMP, where writes are blocked.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= capture_data;
    rd_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_CAPTURE;
      dphase          <= D_INIT;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill            <= '0;
      entries_left    <= '0;
      post_left       <= '0;
      byte_left       <= '0;
      shift           <= '0;
      dump_byte       <= '0;
      dump_byte_valid <= 1'b0;
      armed           <= 1'b1;
      triggered       <= 1'b0;
      done            <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (!fill_full) fill <= fill + FW'(1);
      end

      case (state)
        S_CAPTURE: begin
          if (trigger) begin
            armed     <= 1'b0;
            triggered <= 1'b1;
            if (trig_last) begin
              state  <= S_DUMP;
              dphase <= D_INIT;
            end else begin
              state     <= S_POST;
              post_left <= capture_enable ? PW'(POST_TRIGGER - 1) : PW'(POST_TRIGGER);
            end
          end
        end

        S_POST: begin
          if (capture_enable) begin
            if (post_left == PW'(1)) begin
              state  <= S_DUMP;
              dphase <= D_INIT;
            end else begin
              post_left <= post_left - PW'(1);
            end
          end
        end

        S_DUMP: begin
          case (dphase)
            D_INIT: begin
              rd_ptr          <= oldest;
              entries_left    <= fill;
              dump_byte       <= entry_count[7:0];
              dump_byte_valid <= 1'b1;
              dphase          <= D_HDR0;
            end
            D_HDR0: begin
              if (xfer) begin
                dump_byte <= entry_count[15:8];
                dphase    <= D_HDR1;
              end
            end
            // rd_q already holds the oldest entry here, so the first entry
            // follows the header without a bubble.
            D_HDR1, D_LOAD: begin
              if (xfer || dphase == D_LOAD) begin
                dump_byte       <= rd_ext[7:0];
                shift           <= rd_ext;
                dump_byte_valid <= 1'b1;
                byte_left       <= BCW'(B - 1);
                rd_ptr          <= rd_ptr + AW'(1);
                entries_left    <= entries_left - FW'(1);
                dphase          <= D_BYTES;
              end
            end
            D_BYTES: begin
              if (xfer) begin
                if (byte_left != '0) begin
                  dump_byte <= shift_next[7:0];
                  shift     <= shift_next;
                  byte_left <= byte_left - BCW'(1);
                end else if (entries_left == '0) begin
                  dump_byte_valid <= 1'b0;
                  state           <= S_DONE;
                  triggered       <= 1'b0;
                  done            <= 1'b1;
                end else begin
                  dump_byte_valid <= 1'b0;
                  dphase          <= D_LOAD;
                end
              end
            end
            default: dphase <= D_INIT;
          endcase
        end

        S_DONE: begin
          if (arm) begin
            state  <= S_CAPTURE;
            armed  <= 1'b1;
            done   <= 1'b0;
            wr_ptr <= '0;
            fill   <= '0;
          end
        end

        default: state <= S_CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: 32-bit samples, depth 8, 4 post-trigger samples.
module tb_trace_capture_buffer;
  localparam int W = 32;
  localparam int SIZE = 8;
  localparam int PT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] capture_data = '0;
  logic         capture_enable = 1'b0;
  logic         trigger = 1'b0;
  logic         arm = 1'b0;
  logic         dump_byte_ready = 1'b1;
  logic [7:0]   dump_byte;
  logic         dump_byte_valid;
  logic         armed;
  logic         triggered;
  logic         done;

  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int stall_err;
  int last_cycles;
  bit timed_out;

  trace_capture_buffer #(.CAPTURE_WIDTH_BITS(W), .CAPTURE_SIZE(SIZE), .POST_TRIGGER(PT)) dut (
    .clk(clk), .reset(reset), .capture_data(capture_data), .capture_enable(capture_enable),
    .trigger(trigger), .arm(arm), .dump_byte(dump_byte), .dump_byte_valid(dump_byte_valid),
    .dump_byte_ready(dump_byte_ready), .armed(armed), .triggered(triggered), .done(done));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input int data, input bit trig);
    capture_enable = en;
    capture_data = W'(data);
    trigger = trig;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    capture_enable = 1'b0;
    trigger = 1'b0;
    arm = 1'b0;
    dump_byte_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Header (16-bit LE count) followed by count 4-byte LE entries: first, first+step, ...
  task automatic build_exp(input int first, input int count, input int step);
    exp_q.delete();
    exp_q.push_back(8'(count));
    exp_q.push_back(8'(count >> 8));
    for (int i = 0; i < count; i++) begin
      int v;
      v = first + i * step;
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(v >> (8 * b)));
    end
  endtask

  function automatic int first_diff();
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) return i;
    if (got.size() != exp_q.size()) return (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    return -1;
  endfunction

  // Accept bytes until got holds nbytes or budget cycles pass; tracks hold-stability violations.
  task automatic collect(input int nbytes, input bit rnd, input int budget);
    bit held;
    logic [7:0] held_byte;
    int cyc;
    held = 1'b0;
    held_byte = '0;
    cyc = 0;
    stall_err = 0;
    while (got.size() < nbytes && cyc < budget) begin
      if (held && (dump_byte_valid !== 1'b1 || dump_byte !== held_byte)) stall_err++;
      dump_byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dump_byte_valid && dump_byte_ready) begin
        got.push_back(dump_byte);
        held = 1'b0;
      end else if (dump_byte_valid) begin
        held = 1'b1;
        held_byte = dump_byte;
      end else begin
        held = 1'b0;
      end
      tick();
      cyc++;
    end
    dump_byte_ready = 1'b1;
    timed_out = (got.size() < nbytes);
    last_cycles = cyc;
  endtask

  task automatic wrap_stimulus();
    for (int i = 0; i <= 13; i++) drive(1'b1, i, i == 10);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dump_byte_valid !== 1'b0 || dump_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: valid=%b byte=%02h required valid=0 byte=00", dump_byte_valid, dump_byte);
    end
    checks++;
    if ({armed, triggered, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_status: a/t/d=%b required 100", {armed, triggered, done});
    end
  endtask

  task automatic test_wrap();
    int d;
    do_reset();
    got.delete();
    for (int i = 0; i <= 13; i++) begin
      if (i == 10) begin
        checks++;
        if ({armed, triggered, done} !== 3'b100) begin
          errors++;
          $display("FAIL wrap_pretrig: a/t/d=%b required 100", {armed, triggered, done});
        end
      end
      drive(1'b1, i, i == 10);
      if (i == 10) begin
        checks++;
        if ({armed, triggered, done} !== 3'b010) begin
          errors++;
          $display("FAIL wrap_trig: a/t/d=%b required 010", {armed, triggered, done});
        end
      end
    end
    capture_data = 32'hAA55_AA55;
    trigger = 1'b1;
    collect(34, 1'b0, 100);
    build_exp(6, 8, 1);
    d = first_diff();
    checks++;
    if (timed_out || d != -1) begin
      errors++;
      $display("FAIL wrap_seq: got %0d bytes, first diff at %0d, required %0d bytes", got.size(), d, exp_q.size());
    end
    checks++;
    if (last_cycles > 44) begin
      errors++;
      $display("FAIL wrap_throughput: %0d cycles required <= 44", last_cycles);
    end
    checks++;
    if ({armed, triggered, done} !== 3'b001 || dump_byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: a/t/d=%b valid=%b required 001 valid=0", {armed, triggered, done}, dump_byte_valid);
    end
    repeat (3) tick();
    checks++;
    if ({armed, triggered, done} !== 3'b001 || dump_byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done_hold: a/t/d=%b valid=%b required 001 valid=0", {armed, triggered, done}, dump_byte_valid);
    end
    capture_enable = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic test_no_wrap();
    int d;
    do_reset();
    got.delete();
    for (int i = 0; i <= 5; i++) drive(1'b1, i, i == 2);
    capture_enable = 1'b0;
    trigger = 1'b0;
    collect(26, 1'b0, 100);
    build_exp(0, 6, 1);
    d = first_diff();
    checks++;
    if (timed_out || d != -1) begin
      errors++;
      $display("FAIL nowrap_seq: got %0d bytes, first diff at %0d, required %0d bytes", got.size(), d, exp_q.size());
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL nowrap_done: done=%b required 1", done);
    end
  endtask

  task automatic test_backpressure();
    int d;
    do_reset();
    got.delete();
    wrap_stimulus();
    capture_enable = 1'b0;
    trigger = 1'b0;
    collect(34, 1'b1, 400);
    build_exp(6, 8, 1);
    d = first_diff();
    checks++;
    if (timed_out || d != -1) begin
      errors++;
      $display("FAIL bp_seq: got %0d bytes, first diff at %0d, required %0d bytes", got.size(), d, exp_q.size());
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable stalled cycles, required 0", stall_err);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: done=%b required 1", done);
    end
  endtask

  task automatic test_sparse_enable();
    int d;
    do_reset();
    got.delete();
    for (int c = 0; c <= 13; c++) begin
      drive(c % 2 == 1, c, c >= 6 && c <= 8);
      if (c == 6) begin
        checks++;
        if ({armed, triggered, done} !== 3'b010) begin
          errors++;
          $display("FAIL sparse_trig: a/t/d=%b required 010", {armed, triggered, done});
        end
      end
      if (c == 12) begin
        checks++;
        if (triggered !== 1'b1 || dump_byte_valid !== 1'b0) begin
          errors++;
          $display("FAIL sparse_post: triggered=%b valid=%b required 1 0", triggered, dump_byte_valid);
        end
      end
    end
    capture_enable = 1'b0;
    trigger = 1'b0;
    collect(30, 1'b0, 100);
    build_exp(1, 7, 2);
    d = first_diff();
    checks++;
    if (timed_out || d != -1) begin
      errors++;
      $display("FAIL sparse_seq: got %0d bytes, first diff at %0d, required %0d bytes", got.size(), d, exp_q.size());
    end
  endtask

  task automatic test_rearm();
    int d;
    do_reset();
    got.delete();
    wrap_stimulus();
    capture_enable = 1'b0;
    trigger = 1'b0;
    if (dump_byte_valid && dump_byte_ready) got.push_back(dump_byte);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if (armed !== 1'b0 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL rearm_ignored: armed=%b triggered=%b required 0 1", armed, triggered);
    end
    collect(34, 1'b0, 100);
    build_exp(6, 8, 1);
    d = first_diff();
    checks++;
    if (timed_out || d != -1 || done !== 1'b1) begin
      errors++;
      $display("FAIL rearm_first_seq: got %0d bytes, first diff at %0d, done=%b, required %0d bytes done=1",
               got.size(), d, done, exp_q.size());
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if ({armed, triggered, done} !== 3'b100) begin
      errors++;
      $display("FAIL rearm_armed: a/t/d=%b required 100", {armed, triggered, done});
    end
    got.delete();
    for (int v = 98; v <= 103; v++) drive(1'b1, v, v == 100);
    capture_enable = 1'b0;
    trigger = 1'b0;
    collect(26, 1'b0, 100);
    build_exp(98, 6, 1);
    d = first_diff();
    checks++;
    if (timed_out || d != -1) begin
      errors++;
      $display("FAIL rearm_second_seq: got %0d bytes, first diff at %0d, required %0d bytes", got.size(), d, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_dump();
    int d;
    do_reset();
    got.delete();
    wrap_stimulus();
    capture_enable = 1'b0;
    trigger = 1'b0;
    collect(5, 1'b0, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (dump_byte_valid !== 1'b0 || dump_byte !== 8'h00 || {armed, triggered, done} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_state: valid=%b byte=%02h a/t/d=%b required 0 00 100",
               dump_byte_valid, dump_byte, {armed, triggered, done});
    end
    got.delete();
    for (int v = 200; v <= 203; v++) drive(1'b1, v, v == 200);
    capture_enable = 1'b0;
    trigger = 1'b0;
    collect(18, 1'b0, 100);
    build_exp(200, 4, 1);
    d = first_diff();
    checks++;
    if (timed_out || d != -1) begin
      errors++;
      $display("FAIL midreset_seq: got %0d bytes, first diff at %0d, required %0d bytes", got.size(), d, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_no_wrap();
    test_backpressure();
    test_sparse_enable();
    test_rearm();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
